// File: rtl/countdown_pkg.sv
// Shared types and helpers for the BCD countdown timer: FSM state encoding,
// active-low 7-segment patterns and single-digit BCD arithmetic.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Returns {borrow, digit - 1}; zero wraps to nine and raises the borrow.
    function automatic logic [4:0] bcd_digit_dec(input logic [3:0] digit);
        if (digit == 4'd0) begin
            return {1'b1, 4'd9};
        end
        return {1'b0, digit - 4'd1};
    endfunction

    function automatic logic [3:0] bcd_digit_clamp(input logic [3:0] digit);
        return (digit > 4'd9) ? 4'd9 : digit;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_seg7.sv
// One BCD digit to active-low 7-segment decoder; non-decimal codes blank the digit.
module bcd_seg7
    import countdown_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_countdown_timer.sv
// N-digit BCD countdown timer with prescaler, run/pause control, one-shot or
// auto-reload behaviour and per-digit active-low 7-segment outputs.
module bcd_countdown_timer
    import countdown_pkg::*;
#(
    parameter int                  CLK_HZ    = 50_000_000,
    parameter int                  TICK_HZ   = 1,
    parameter int                  DIGITS    = 2,
    parameter logic [4*DIGITS-1:0] RESET_VAL = 8'h30
) (
    input  logic                  Clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  auto_reload,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  tick,
    output logic                  done,
    output logic                  expired
);

    localparam int              DIV        = CLK_HZ / TICK_HZ;
    localparam int              PW         = $clog2(DIV);
    localparam int              W          = 4 * DIGITS;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);

    // Whole-value BCD decrement: the borrow ripples from the lowest digit up.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] value);
        logic [W-1:0] result;
        logic         borrow;
        logic [4:0]   step;
        result = value;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                step              = bcd_digit_dec(value[4*i +: 4]);
                result[4*i +: 4]  = step[3:0];
                borrow            = step[4];
            end
        end
        return result;
    endfunction

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] value);
        logic [W-1:0] result;
        for (int i = 0; i < DIGITS; i++) begin
            result[4*i +: 4] = bcd_digit_clamp(value[4*i +: 4]);
        end
        return result;
    endfunction

    state_e        state_q,   state_d;
    logic [W-1:0]  bcd_q,     bcd_d;
    logic [W-1:0]  reload_q,  reload_d;
    logic [PW-1:0] presc_q,   presc_d;
    logic          tick_q,    tick_d;
    logic          done_q,    done_d;
    logic          expired_q, expired_d;
    logic [W-1:0]  bcd_next;

    assign bcd_next = bcd_dec(bcd_q);

    always_comb begin
        // NOTE: every signal gets a hold/default value first so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        bcd_d    = bcd_q;
        reload_d = reload_q;
        presc_d  = presc_q;
        tick_d   = 1'b0;
        done_d   = 1'b0;

        if (load) begin
            bcd_d    = bcd_clamp(load_val);
            reload_d = bcd_clamp(load_val);
            presc_d  = '0;
            state_d  = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (!pause && start) begin
                        if (bcd_q == '0) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        if (bcd_q == '0) begin
                            // Parked at zero in auto-reload: restart from the reload value.
                            if (auto_reload && reload_q != '0) begin
                                bcd_d = reload_q;
                            end else begin
                                state_d = ST_EXPIRED;
                            end
                        end else begin
                            bcd_d = bcd_next;
                            if (bcd_next == '0) begin
                                done_d = 1'b1;
                                if (!auto_reload || reload_q == '0) begin
                                    state_d = ST_EXPIRED;
                                end
                            end
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        expired_d = (state_d == ST_EXPIRED);
    end

    always_ff @(posedge Clk) begin
        // NOTE: registered state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (!rst) begin
            state_q   <= ST_IDLE;
            bcd_q     <= RESET_VAL;
            reload_q  <= RESET_VAL;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            reload_q  <= reload_d;
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_seg7 u_seg7 (
            .digit (bcd_q[4*i +: 4]),
            .seg   (seg[7*i +: 7])
        );
    end

    assign bcd     = bcd_q;
    assign tick    = tick_q;
    assign done    = done_q;
    assign expired = expired_q;

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Parametrised multi-digit BCD down-counter with an integrated 1-of-N clock prescaler, run/pause control, one-shot or auto-reload mode, and per-digit active-low 7-segment outputs. It drives board HEX displays directly from the 50 MHz system clock. It generalises the fixed two-digit countdown to N digits, with a loadable start value, pause, and a terminal-count flag.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency.
- `TICK_HZ`, 1, decrement rate. Prescaler divisor `DIV = CLK_HZ/TICK_HZ`, which must be ≥ 2.
- `DIGITS`, 2, number of BCD digits (1..8).
- `RESET_VAL`, 8'h30, BCD value loaded at reset. Width is `4*DIGITS`.
- `Clk` input 1: system clock, rising-edge.
- `rst` input 1: reset, synchronous, active-low.
- `load` input 1: load `load_val` into count and reload register.
- `load_val` input 4*DIGITS: BCD start value.
- `start` input 1: begin or resume counting.
- `pause` input 1: halt counting and freeze the prescaler.
- `auto_reload` input 1: 1 = reload and continue at zero; 0 = stop at zero.
- `bcd` output 4*DIGITS: current count, registered.
- `seg` output 7*DIGITS: active-low segments {g..a}. Digit i occupies `seg[7i+6:7i]`.
- `tick` output 1: one-cycle pulse each prescaler wrap while in RUN.
- `done` output 1: one-cycle pulse when the count reaches zero.
- `expired` output 1: level, high in state EXPIRED.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED.
- Reset (`rst`=0 at an edge) sets:
  - state IDLE
  - `bcd` and reload register = RESET_VAL
  - prescaler = 0
  - `tick`, `done`, `expired` = 0
- Priority at any edge: reset > load > pause > start > tick decrement.
- `load` applies in any state:
  - `bcd` and reload register take `load_val`. Any nibble > 9 is clamped to 9.
  - Prescaler clears and state goes to IDLE.
  - `done` is not asserted.
- `start`:
  - In IDLE or PAUSE with `bcd` ≠ 0: go to RUN.
  - In IDLE or PAUSE with `bcd` = 0: go to EXPIRED and pulse `done`.
  - In RUN or EXPIRED: ignored.
- `pause` in RUN: go to PAUSE. The prescaler holds its value, so on resume the partial tick period continues. `start` and `pause` asserted together in RUN: pause wins.
- RUN behaviour:
  - The prescaler counts 0..DIV-1.
  - On the edge where it wraps from DIV-1 to 0, `tick`=1 and `bcd` decrements by one in BCD.
  - BCD decrement: the lowest nibble goes 0→9 with a borrow, and the borrow ripples upward (e.g. 8'h30 → 8'h29, 8'h10 → 8'h09).
- Reaching zero (the decrement produces all-zero):
  - `done` pulses on the same edge that `bcd` becomes 0.
  - If `auto_reload`=0: go to EXPIRED and hold 0.
  - If `auto_reload`=1: on the next tick `bcd` takes the reload register instead of decrementing, state stays RUN, `done` is not re-pulsed.
  - If the reload register is 0 with `auto_reload`=1: go to EXPIRED.
- EXPIRED exits only via `load` or reset.
- Segment map (combinational from `bcd`, per digit):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - any other value = 1111111 (blank)

## Timing
- All state, `bcd`, `tick`, `done`, and `expired` are registered. `seg` is combinational from registered `bcd` (zero added latency).
- `load` at edge n: `bcd` is valid after edge n. The first decrement follows DIV RUN cycles after `start` is sampled.
- `start` at edge n: the prescaler counts from edge n+1. The first `tick` and decrement occur DIV edges after n.
- `tick` and `done` are exactly one cycle wide. `done` coincides with `bcd` = 0.
- A reset or load in mid-count aborts it immediately. There is no partial decrement and no `done`.

## Structure
- Shared package `countdown_pkg` holds:
  - the state enum
  - the 10 segment constants plus the blank constant
  - a BCD-digit-decrement function returning {borrow, digit}
- One sub-module `bcd_seg7`: 4-bit BCD in, 7-bit active-low segments out, instanced DIGITS times through generate.
- The prescaler and FSM stay in the top module. The prescaler width is `$clog2(DIV)`.

## Test plan
All scenarios use DIV=4, DIGITS=2.
- Reset with RESET_VAL=8'h30, then `start`:
  - `bcd` 30→29→28 at 4-cycle intervals, with a `tick` pulse at each step.
  - `seg[13:7]`=0110000, `seg[6:0]`=1000000 before the first tick.
- `load` 8'h03 then `start`, with `auto_reload`=0:
  - sequence 03, 02, 01, 00.
  - `done` for one cycle together with 00, then `expired`=1.
  - further `start` is ignored.
- `load` 8'h02, `auto_reload`=1, `start`:
  - sequence 02, 01, 00 (`done` pulses), then 02, 01, 00 (`done` again).
  - `expired` stays 0.
- Pause 2 cycles into a tick period, hold 10 cycles, then `start`:
  - the next decrement arrives 2 cycles after resume.
  - `start` and `pause` asserted together in RUN leaves the state in PAUSE.
- `load` 8'hAF: `bcd`=8'h99. `load` 8'h00 then `start`: EXPIRED next edge with a `done` pulse.
- `rst`=0 mid-count at `bcd`=8'h15: next edge `bcd`=RESET_VAL, state IDLE, all flags 0.
